// File: rtl/apb_node_regslice.sv
// APB 1-to-NB_SLAVES node: registered request path, inclusive range decode, decode-error response.
// Define APB_NODE_TIMEOUT_EN to enable the per-transfer access timeout and timeout_o pulse.
module apb_node_regslice #(
    parameter int NB_SLAVES  = 9,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] START_ADDR = {
        32'h1A11_0000, 32'h1A10_7000, 32'h1A10_6000, 32'h1A10_5000, 32'h1A10_4000,
        32'h1A10_3000, 32'h1A10_2000, 32'h1A10_1000, 32'h1A10_0000},
    parameter logic [NB_SLAVES*ADDR_WIDTH-1:0] END_ADDR = {
        32'h1A11_7FFF, 32'h1A10_7FFF, 32'h1A10_6FFF, 32'h1A10_5FFF, 32'h1A10_4FFF,
        32'h1A10_3FFF, 32'h1A10_2FFF, 32'h1A10_1FFF, 32'h1A10_0FFF},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           s_paddr,
    input  logic [DATA_WIDTH-1:0]           s_pwdata,
    input  logic                            s_pwrite,
    input  logic                            s_psel,
    input  logic                            s_penable,
    output logic [DATA_WIDTH-1:0]           s_prdata,
    output logic                            s_pready,
    output logic                            s_pslverr,
    output logic [ADDR_WIDTH-1:0]           m_paddr,
    output logic [DATA_WIDTH-1:0]           m_pwdata,
    output logic                            m_pwrite,
    output logic [NB_SLAVES-1:0]            m_psel,
    output logic                            m_penable,
    input  logic [NB_SLAVES*DATA_WIDTH-1:0] m_prdata,
    input  logic [NB_SLAVES-1:0]            m_pready,
    input  logic [NB_SLAVES-1:0]            m_pslverr,
    output logic                            timeout_o
);

    localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, M_SETUP, M_ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    slverr_q, slverr_d;
    logic [IDX_W:0]          dec;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    sel_ready;
    logic                    sel_err;

`ifdef APB_NODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;
`else
    logic                    unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Returns {hit, index}; scanning downwards lets the lowest matching index win on overlap.
    function automatic logic [IDX_W:0] decode(input logic [ADDR_WIDTH-1:0] a);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if (a >= START_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] &&
                a <= END_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH])
                r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    assign dec = decode(s_paddr);

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (int'(idx_q) == i) begin
                sel_rdata = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ready = m_pready[i];
                sel_err   = m_pslverr[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        slverr_d = slverr_q;
`ifdef APB_NODE_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s_psel && !s_penable) begin
                    addr_d  = s_paddr;
                    wdata_d = s_pwdata;
                    write_d = s_pwrite;
                    if (dec[IDX_W]) begin
                        idx_d   = dec[IDX_W-1:0];
                        state_d = M_SETUP;
                    end else begin
                        rdata_d  = '0;
                        slverr_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            M_SETUP: begin
                state_d = M_ACCESS;
`ifdef APB_NODE_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            M_ACCESS: begin
                // A response on the final allowed cycle takes priority over the timeout.
                if (sel_ready) begin
                    rdata_d  = sel_rdata;
                    slverr_d = sel_err;
                    state_d  = RESP;
                end
`ifdef APB_NODE_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
`ifdef APB_NODE_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            slverr_q <= slverr_d;
`ifdef APB_NODE_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        m_psel = '0;
        if (state_q == M_SETUP || state_q == M_ACCESS) begin
            for (int i = 0; i < NB_SLAVES; i++)
                m_psel[i] = (int'(idx_q) == i);
        end
    end

    assign m_penable = (state_q == M_ACCESS);
    assign m_paddr   = addr_q;
    assign m_pwdata  = wdata_q;
    assign m_pwrite  = write_q;
    assign s_pready  = (state_q == RESP);
    assign s_prdata  = (state_q == RESP) ? rdata_q : '0;
    assign s_pslverr = (state_q == RESP) && slverr_q;

`ifdef APB_NODE_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_node_regslice.sv
// Self-checking bench for apb_node_regslice: directed vector table, corner sequences,
// randomized transfers against a behavioural address-map/response model.
module tb_apb_node_regslice;

    localparam int NS = 9;
    localparam int TC = 4;
`ifdef APB_NODE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       s_paddr = '0, s_pwdata = '0;
    logic              s_pwrite = 1'b0, s_psel = 1'b0, s_penable = 1'b0;
    logic [31:0]       s_prdata;
    logic              s_pready, s_pslverr;
    logic [31:0]       m_paddr, m_pwdata;
    logic              m_pwrite, m_penable, timeout_o;
    logic [NS-1:0]     m_psel;
    logic [NS*32-1:0]  m_prdata;
    logic [NS-1:0]     m_pready, m_pslverr;

    // Second instance with an overlapping two-slave map.
    logic [31:0]       o_paddr = '0;
    logic              o_psel = 1'b0, o_penable = 1'b0;
    logic [31:0]       o_s_prdata;
    logic              o_s_pready;
    logic [1:0]        o_m_psel;
    logic [31:0]       o_unused_paddr, o_unused_pwdata;
    logic              o_unused_pwrite, o_unused_penable, o_unused_pslverr, o_unused_timeout;

    always #5 clk = ~clk;

    apb_node_regslice #(.TIMEOUT_CYCLES(TC)) u_dut (
        .clk(clk), .rst(rst),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_psel(s_psel), .s_penable(s_penable),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .timeout_o(timeout_o)
    );

    apb_node_regslice #(
        .NB_SLAVES(2),
        .START_ADDR({32'h0000_0800, 32'h0000_0000}),
        .END_ADDR({32'h0000_1FFF, 32'h0000_0FFF}),
        .TIMEOUT_CYCLES(TC)
    ) u_ovl (
        .clk(clk), .rst(rst),
        .s_paddr(o_paddr), .s_pwdata(32'h0), .s_pwrite(1'b0),
        .s_psel(o_psel), .s_penable(o_penable),
        .s_prdata(o_s_prdata), .s_pready(o_s_pready), .s_pslverr(o_unused_pslverr),
        .m_paddr(o_unused_paddr), .m_pwdata(o_unused_pwdata), .m_pwrite(o_unused_pwrite),
        .m_psel(o_m_psel), .m_penable(o_unused_penable),
        .m_prdata({32'h0000_BBBB, 32'h0000_AAAA}), .m_pready(2'b11), .m_pslverr(2'b00),
        .timeout_o(o_unused_timeout)
    );

    // Behavioural slaves: slave i raises pready after wait_cfg[i] access cycles (-1 = never).
    logic [31:0] slave_rdata [NS];
    logic [NS-1:0] slave_err;
    int          wait_cfg [NS];
    int          acc;
    logic [31:0] map_s [NS];
    logic [31:0] map_e [NS];

    always_ff @(posedge clk)
        acc <= (m_penable && (|m_psel)) ? acc + 1 : 0;

    always_comb begin
        m_prdata  = '0;
        m_pready  = '0;
        m_pslverr = '0;
        for (int i = 0; i < NS; i++) begin
            m_prdata[i*32 +: 32] = slave_rdata[i];
            m_pslverr[i]         = slave_err[i];
            m_pready[i]          = m_psel[i] && m_penable && (wait_cfg[i] >= 0) && (acc >= wait_cfg[i]);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Results of the last upstream transfer.
    logic [31:0] r_rdata, paddr_t2, pwdata_t2;
    logic        r_err, r_to, r_hang, quiet_ok, psel_any, pen_t1, pen_t2, pwrite_t2;
    logic [NS-1:0] psel_t1, psel_t2;
    int          r_k;

    // Upstream cycle index k: T0 is the setup cycle; returns at the negedge of the response cycle.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w, input int bound);
        logic done;
        @(negedge clk);
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = a; s_pwdata = d; s_pwrite = w;
        done = 1'b0; quiet_ok = 1'b1; psel_any = 1'b0; r_k = 0;
        r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
        psel_t1 = '0; psel_t2 = '0; pen_t1 = 1'b0; pen_t2 = 1'b0;
        paddr_t2 = '0; pwdata_t2 = '0; pwrite_t2 = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            r_k = k;
            s_penable = 1'b1;
            psel_any = psel_any | (|m_psel);
            if (k == 1) begin psel_t1 = m_psel; pen_t1 = m_penable; end
            if (k == 2) begin
                psel_t2 = m_psel; pen_t2 = m_penable;
                paddr_t2 = m_paddr; pwdata_t2 = m_pwdata; pwrite_t2 = m_pwrite;
            end
            if (s_pready) begin
                r_rdata = s_prdata; r_err = s_pslverr; r_to = timeout_o;
                done = 1'b1;
                break;
            end else if (s_prdata != '0 || s_pslverr || timeout_o) begin
                quiet_ok = 1'b0;
            end
        end
        r_hang = !done;
        if (done) begin s_psel = 1'b0; s_penable = 1'b0; end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_m_psel"}, 32'(m_psel), 32'h0);
        chk({tag, "_m_paddr"}, m_paddr, 32'h0);
        chk({tag, "_m_pwdata"}, m_pwdata, 32'h0);
        chk({tag, "_s_prdata"}, s_prdata, 32'h0);
        chk({tag, "_ctl"}, 32'({m_penable, m_pwrite, s_pready, s_pslverr, timeout_o}), 32'h0);
    endtask

    task automatic ovl_xfer(input logic [31:0] a, input logic [1:0] exp_sel, input logic [31:0] exp_d,
                            input string tag);
        @(negedge clk); o_psel = 1'b1; o_penable = 1'b0; o_paddr = a;
        @(negedge clk); o_penable = 1'b1;
        chk({tag, "_psel"}, 32'(o_m_psel), 32'(exp_sel));
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_pready"}, 32'(o_s_pready), 32'h1);
        chk({tag, "_rdata"}, o_s_prdata, exp_d);
        o_psel = 1'b0; o_penable = 1'b0;
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if (a >= map_s[i] && a <= map_e[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        int          slv;
        int          wait_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_k;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            map_s[i] = 32'h1A10_0000 + 32'(i) * 32'h1000;
            map_e[i] = map_s[i] + 32'h0FFF;
        end
        map_s[8] = 32'h1A11_0000;
        map_e[8] = 32'h1A11_7FFF;
        for (int i = 0; i < NS; i++) begin
            slave_rdata[i] = {16'hA0A0, 16'(i)};
            wait_cfg[i]    = 0;
        end
        slave_rdata[1] = 32'h1234_5678;
        slave_err      = 9'b0_1000_0000;

        vecs[0] = '{32'h1A10_1004, 32'h0,         1'b0,  1, 0, 32'h1234_5678, 1'b0, 3};
        vecs[1] = '{32'h1A11_7FFC, 32'hCAFE_F00D, 1'b1,  8, 3, 32'hA0A0_0008, 1'b0, 6};
        vecs[2] = '{32'h1A10_8000, 32'h0,         1'b0, -1, 0, 32'h0,         1'b1, 1};
        vecs[3] = '{32'h1A10_0000, 32'h0,         1'b0,  0, 1, 32'hA0A0_0000, 1'b0, 4};
        vecs[4] = '{32'h1A10_7FFF, 32'h5555_AAAA, 1'b1,  7, 0, 32'hA0A0_0007, 1'b1, 3};
        vecs[5] = '{32'h1A0F_FFFF, 32'h0,         1'b0, -1, 0, 32'h0,         1'b1, 1};
        vecs[6] = '{32'h1A11_8000, 32'h0,         1'b1, -1, 0, 32'h0,         1'b1, 1};
        vecs[7] = '{32'h1A10_3000, 32'h0,         1'b0,  3, 3, 32'hA0A0_0003, 1'b0, 6};
        vecs[8] = '{32'h1A10_FFFF, 32'h0,         1'b0, -1, 0, 32'h0,         1'b1, 1};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_ovl_psel", 32'({o_m_psel, o_s_pready}), 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].slv >= 0) wait_cfg[vecs[v].slv] = vecs[v].wait_n;
            xfer(vecs[v].addr, vecs[v].wdata, vecs[v].write, 40);
            chk($sformatf("vec%0d_hang", v), 32'(r_hang), 32'h0);
            chk($sformatf("vec%0d_cycles", v), 32'(r_k), 32'(vecs[v].exp_k));
            chk($sformatf("vec%0d_rdata", v), r_rdata, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_slverr", v), 32'(r_err), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_timeout", v), 32'(r_to), 32'h0);
            chk($sformatf("vec%0d_quiet", v), 32'(quiet_ok), 32'h1);
            if (vecs[v].slv >= 0) begin
                chk($sformatf("vec%0d_psel_t1", v), 32'(psel_t1), 32'h1 << vecs[v].slv);
                chk($sformatf("vec%0d_psel_t2", v), 32'(psel_t2), 32'h1 << vecs[v].slv);
                chk($sformatf("vec%0d_penable", v), 32'({pen_t1, pen_t2}), 32'h1);
                chk($sformatf("vec%0d_paddr", v), paddr_t2, vecs[v].addr);
                chk($sformatf("vec%0d_pwdata", v), pwdata_t2, vecs[v].wdata);
                chk($sformatf("vec%0d_pwrite", v), 32'(pwrite_t2), 32'(vecs[v].write));
            end else begin
                chk($sformatf("vec%0d_no_psel", v), 32'(psel_any), 32'h0);
            end
        end

        // Slave 3 never ready.
        wait_cfg[3] = -1;
        if (TO_EN) begin
            xfer(32'h1A10_3000, 32'h0, 1'b0, 40);
            chk("to_cycles", 32'(r_k), 32'(2 + TC));
            chk("to_slverr", 32'(r_err), 32'h1);
            chk("to_rdata", r_rdata, 32'h0);
            chk("to_pulse", 32'(r_to), 32'h1);
            @(negedge clk);
            chk("to_pulse_end", 32'(timeout_o), 32'h0);
        end else begin
            xfer(32'h1A10_3000, 32'h0, 1'b0, 20);
            chk("hang_no_resp", 32'(r_hang), 32'h1);
            chk("hang_psel_held", 32'(m_psel), 32'h008);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
            check_idle_outputs("hang_reset");
        end

        // Reset in the middle of an access phase.
        wait_cfg[0] = -1;
        @(negedge clk); s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h1A10_0010; s_pwdata = 32'h7777_0000;
        @(negedge clk); s_penable = 1'b1;
        @(negedge clk);
        chk("midrst_access", 32'({m_penable, m_psel}), 32'h201);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        wait_cfg[0] = 0;
        xfer(32'h1A10_0010, 32'h0, 1'b0, 40);
        chk("postrst_cycles", 32'(r_k), 32'h3);
        chk("postrst_rdata", r_rdata, slave_rdata[0]);

        ovl_xfer(32'h0000_0900, 2'b01, 32'h0000_AAAA, "ovl_900");
        ovl_xfer(32'h0000_0FFF, 2'b01, 32'h0000_AAAA, "ovl_fff");
        ovl_xfer(32'h0000_1000, 2'b10, 32'h0000_BBBB, "ovl_1000");

        for (int n = 0; n < 80; n++) begin
            int          idx, w, s, exp_k;
            logic [31:0] a, d, exp_rd;
            logic        wr, exp_err, exp_to;
            for (int i = 0; i < NS; i++) slave_rdata[i] = $urandom();
            slave_err = NS'($urandom());
            s = int'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 5))
                0:       a = $urandom();
                1:       a = map_s[s];
                2:       a = map_e[s];
                3:       a = map_e[s] + 32'h1;
                default: a = map_s[s] + $urandom_range(0, map_e[s] - map_s[s]);
            endcase
            d  = $urandom();
            wr = 1'($urandom_range(0, 1));
            w  = TO_EN ? int'($urandom_range(0, 7)) - 1 : int'($urandom_range(0, 4));
            for (int i = 0; i < NS; i++) wait_cfg[i] = w;

            idx = ref_decode(a);
            if (idx < 0) begin
                exp_rd = '0; exp_err = 1'b1; exp_k = 1; exp_to = 1'b0;
            end else if (TO_EN && (w < 0 || w >= TC)) begin
                exp_rd = '0; exp_err = 1'b1; exp_k = 2 + TC; exp_to = 1'b1;
            end else begin
                exp_rd = slave_rdata[idx]; exp_err = slave_err[idx]; exp_k = 3 + w; exp_to = 1'b0;
            end

            xfer(a, d, wr, 40);
            chk($sformatf("rnd%0d_cycles a=%0h", n, a), 32'(r_k), 32'(exp_k));
            chk($sformatf("rnd%0d_rdata a=%0h", n, a), r_rdata, exp_rd);
            chk($sformatf("rnd%0d_slverr a=%0h", n, a), 32'(r_err), 32'(exp_err));
            chk($sformatf("rnd%0d_timeout a=%0h", n, a), 32'(r_to), 32'(exp_to));
            if (idx >= 0) begin
                chk($sformatf("rnd%0d_psel", n), 32'(psel_t2), 32'h1 << idx);
                chk($sformatf("rnd%0d_req", n), paddr_t2 ^ pwdata_t2, a ^ d);
            end else begin
                chk($sformatf("rnd%0d_no_psel", n), 32'(psel_any), 32'h0);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
